ahb_arbiter: RTL and testbench

//   Three-master AHB bus arbiter. Drives one-hot hgrant_1..3 into the master write/address mux.

---
 rtl/ahb_arbiter.sv | 132 +++++++++++++
 tb/tb_ahb_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// Three-master AHB arbiter: registered one-hot grants, burst/lock protection,
// round-robin or fixed priority, parking on DEFAULT_MASTER when idle.
module ahb_arbiter #(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned DEFAULT_MASTER = 1
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic       hbusreq_1,
  input  logic       hbusreq_2,
  input  logic       hbusreq_3,
  input  logic       hlock_1,
  input  logic       hlock_2,
  input  logic       hlock_3,
  input  logic       hready,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  output logic       hgrant_1,
  output logic       hgrant_2,
  output logic       hgrant_3,
  output logic [1:0] hmaster,
  output logic       hmastlock
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);
  localparam logic [2:0] DEF_GNT = 3'(1 << (DEFAULT_MASTER - 1));

  logic [2:0] grant_q,     grant_d;
  logic [1:0] ptr_q,       ptr_d;
  logic [3:0] cnt_q,       cnt_d;
  logic [1:0] hmaster_q,   hmaster_d;
  logic       hmastlock_q, hmastlock_d;

  logic [2:0] req, lck;
  logic [3:0] len_m1;
  logic       lock_hold, arb_en;
  logic [1:0] cand1, cand2, win_idx;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd3) ? 2'd1 : i + 2'd1;
  endfunction

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] i);
    return 3'b001 << (i - 2'd1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req = {hbusreq_3, hbusreq_2, hbusreq_1};
    lck = {hlock_3, hlock_2, hlock_1};

    case (hburst)
      3'b010, 3'b011: len_m1 = 4'd3;
      3'b100, 3'b101: len_m1 = 4'd7;
      3'b110, 3'b111: len_m1 = 4'd15;
      default:        len_m1 = 4'd0;
    endcase

    cnt_d = cnt_q;
    if (hready) begin
      if (htrans_e'(htrans) == TR_NONSEQ)                  cnt_d = len_m1;
      else if (htrans_e'(htrans) == TR_SEQ && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    end

    lock_hold = |(grant_q & lck);
    arb_en    = hready & ~lock_hold & (cnt_d == 4'd0);

    // Rotating order ptr+1, ptr+2, ptr: the current owner is the last resort.
    cand1   = next_idx(ptr_q);
    cand2   = next_idx(cand1);
    win_idx = DEF_IDX;
    if (ROUND_ROBIN) begin
      if      (req[cand1 - 2'd1]) win_idx = cand1;
      else if (req[cand2 - 2'd1]) win_idx = cand2;
      else if (req[ptr_q - 2'd1]) win_idx = ptr_q;
    end else begin
      if      (req[0]) win_idx = 2'd1;
      else if (req[1]) win_idx = 2'd2;
      else if (req[2]) win_idx = 2'd3;
    end

    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (arb_en) begin
      grant_d = idx_to_onehot(win_idx);
      if (|req) ptr_d = win_idx;
    end

    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (hready) begin
      case (grant_q)
        3'b001:  hmaster_d = 2'd1;
        3'b010:  hmaster_d = 2'd2;
        3'b100:  hmaster_d = 2'd3;
        default: hmaster_d = DEF_IDX;
      endcase
      hmastlock_d = lock_hold;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset restores every flop so an abandoned burst or lock leaves nothing behind.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      grant_q     <= DEF_GNT;
      ptr_q       <= DEF_IDX;
      cnt_q       <= 4'd0;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign hgrant_1  = grant_q[0];
  assign hgrant_2  = grant_q[1];
  assign hgrant_3  = grant_q[2];
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: each directed step queues its expected
// {grant, hmaster, hmastlock}; a monitor pops and compares after every edge.
module tb_ahb_arbiter;

  logic       hclk = 1'b0;
  logic       hreset;
  logic       hbusreq_1, hbusreq_2, hbusreq_3;
  logic       hlock_1, hlock_2, hlock_3;
  logic       hready;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hgrant_1, hgrant_2, hgrant_3;
  logic [1:0] hmaster;
  logic       hmastlock;

  localparam logic [1:0] ID = 2'b00, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SGL = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101;

  typedef struct {
    string      name;
    logic [2:0] grant;
    logic [1:0] master;
    logic       lock;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 1'b0;

  ahb_arbiter #(.ROUND_ROBIN(1'b1), .DEFAULT_MASTER(1)) dut (
    .hclk(hclk), .hreset(hreset),
    .hbusreq_1(hbusreq_1), .hbusreq_2(hbusreq_2), .hbusreq_3(hbusreq_3),
    .hlock_1(hlock_1), .hlock_2(hlock_2), .hlock_3(hlock_3),
    .hready(hready), .htrans(htrans), .hburst(hburst),
    .hgrant_1(hgrant_1), .hgrant_2(hgrant_2), .hgrant_3(hgrant_3),
    .hmaster(hmaster), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
               nm, act[5:3], act[2:1], act[0], exp[5:3], exp[2:1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs away from the active edge and queue the state expected after it.
  task automatic step(input string nm, input logic rst, input logic [2:0] req,
                      input logic [2:0] lck, input logic rdy, input logic [1:0] tr,
                      input logic [2:0] bu, input logic [2:0] eg, input logic [1:0] em,
                      input logic el);
    exp_t e;
    @(negedge hclk);
    hreset = rst;
    {hbusreq_3, hbusreq_2, hbusreq_1} = req;
    {hlock_3, hlock_2, hlock_1} = lck;
    hready = rdy;
    htrans = tr;
    hburst = bu;
    e.name = nm; e.grant = eg; e.master = em; e.lock = el;
    q.push_back(e);
  endtask

  // Monitor: every edge produces an output, compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, {hgrant_3, hgrant_2, hgrant_1, hmaster, hmastlock},
              {e.grant, e.master, e.lock});
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    hreset = 1'b1;
    {hbusreq_3, hbusreq_2, hbusreq_1} = 3'b000;
    {hlock_3, hlock_2, hlock_1} = 3'b000;
    hready = 1'b1; htrans = ID; hburst = SGL;

    // T1 reset parks on master 1
    step("t1_rst0", 1, 3'b000, 3'b000, 1, ID, SGL, 3'b001, 2'd1, 0);
    step("t1_rst1", 1, 3'b000, 3'b000, 1, ID, SGL, 3'b001, 2'd1, 0);

    // T2 round robin with all three requesting single transfers
    step("t2_rr_a", 0, 3'b111, 3'b000, 1, NS, SGL, 3'b010, 2'd1, 0);
    step("t2_rr_b", 0, 3'b111, 3'b000, 1, NS, SGL, 3'b100, 2'd2, 0);
    step("t2_rr_c", 0, 3'b111, 3'b000, 1, NS, SGL, 3'b001, 2'd3, 0);
    step("t2_rr_d", 0, 3'b111, 3'b000, 1, NS, SGL, 3'b010, 2'd1, 0);
    step("t2_rr_e", 0, 3'b111, 3'b000, 1, NS, SGL, 3'b100, 2'd2, 0);

    // T3 INCR4 by master 2 is not interrupted by master 3's request
    step("t3_g2",    0, 3'b010, 3'b000, 1, ID, SGL,   3'b010, 2'd3, 0);
    step("t3_own2",  0, 3'b010, 3'b000, 1, ID, SGL,   3'b010, 2'd2, 0);
    step("t3_ns",    0, 3'b110, 3'b000, 1, NS, INCR4, 3'b010, 2'd2, 0);
    step("t3_seq1",  0, 3'b110, 3'b000, 1, SQ, INCR4, 3'b010, 2'd2, 0);
    step("t3_seq2",  0, 3'b110, 3'b000, 1, SQ, INCR4, 3'b010, 2'd2, 0);
    step("t3_seq3",  0, 3'b110, 3'b000, 1, SQ, INCR4, 3'b100, 2'd2, 0);
    step("t3_own3",  0, 3'b100, 3'b000, 1, ID, SGL,   3'b100, 2'd3, 0);

    // T4 same burst with a three-cycle hready stall mid-burst
    step("t4_g2",    0, 3'b010, 3'b000, 1, ID, SGL,   3'b010, 2'd3, 0);
    step("t4_own2",  0, 3'b010, 3'b000, 1, ID, SGL,   3'b010, 2'd2, 0);
    step("t4_ns",    0, 3'b110, 3'b000, 1, NS, INCR4, 3'b010, 2'd2, 0);
    step("t4_seq1",  0, 3'b110, 3'b000, 1, SQ, INCR4, 3'b010, 2'd2, 0);
    step("t4_stl1",  0, 3'b110, 3'b000, 0, SQ, INCR4, 3'b010, 2'd2, 0);
    step("t4_stl2",  0, 3'b110, 3'b000, 0, SQ, INCR4, 3'b010, 2'd2, 0);
    step("t4_stl3",  0, 3'b110, 3'b000, 0, SQ, INCR4, 3'b010, 2'd2, 0);
    step("t4_seq2",  0, 3'b110, 3'b000, 1, SQ, INCR4, 3'b010, 2'd2, 0);
    step("t4_seq3",  0, 3'b110, 3'b000, 1, SQ, INCR4, 3'b100, 2'd2, 0);
    step("t4_own3",  0, 3'b100, 3'b000, 1, ID, SGL,   3'b100, 2'd3, 0);

    // T5 locked sequence by master 1 holds off master 2
    step("t5_g1",    0, 3'b001, 3'b001, 1, ID, SGL, 3'b001, 2'd3, 0);
    step("t5_lk1",   0, 3'b011, 3'b001, 1, NS, SGL, 3'b001, 2'd1, 1);
    step("t5_lk2",   0, 3'b011, 3'b001, 1, NS, SGL, 3'b001, 2'd1, 1);
    step("t5_lk3",   0, 3'b011, 3'b001, 1, NS, SGL, 3'b001, 2'd1, 1);
    step("t5_lk4",   0, 3'b011, 3'b001, 1, NS, SGL, 3'b001, 2'd1, 1);
    step("t5_unlk",  0, 3'b011, 3'b000, 1, NS, SGL, 3'b010, 2'd1, 0);
    step("t5_own2",  0, 3'b010, 3'b000, 1, ID, SGL, 3'b010, 2'd2, 0);
    // stray hlock from a non-requesting master is ignored; then park on default
    step("t5_stray", 0, 3'b010, 3'b100, 1, ID, SGL, 3'b010, 2'd2, 0);
    step("t5_park",  0, 3'b000, 3'b100, 1, ID, SGL, 3'b001, 2'd2, 0);
    step("t5_park2", 0, 3'b000, 3'b000, 1, ID, SGL, 3'b001, 2'd1, 0);

    // T6 reset in the middle of master 3's INCR8
    step("t6_g3",    0, 3'b100, 3'b000, 1, ID, SGL,   3'b100, 2'd1, 0);
    step("t6_own3",  0, 3'b100, 3'b000, 1, ID, SGL,   3'b100, 2'd3, 0);
    step("t6_ns",    0, 3'b110, 3'b000, 1, NS, INCR8, 3'b100, 2'd3, 0);
    step("t6_seq1",  0, 3'b110, 3'b000, 1, SQ, INCR8, 3'b100, 2'd3, 0);
    step("t6_rst",   1, 3'b110, 3'b000, 1, SQ, INCR8, 3'b001, 2'd1, 0);
    step("t6_req2",  0, 3'b010, 3'b000, 1, ID, SGL,   3'b010, 2'd1, 0);
    step("t6_idle",  0, 3'b000, 3'b000, 1, ID, SGL,   3'b001, 2'd2, 0);

    @(posedge hclk);
    @(posedge hclk);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
